rom_sweep_reader: RTL
=====================

# rom_sweep_reader

Parametrised successor to the single-step ROM reader for 556PT5 (3604, 512×8) and 556PT4 (3601, 256×4) bipolar PROMs.
- Drives the chip's V1–V4 operation lines and address bus.
- Waits a configurable access/settle time, then samples the data bus.
- Streams {address, data} words out through a valid/ready handshake.
- Two modes: automatic full-address sweep (dump), and manual single-step increment/decrement with wrap-around in both directions.

## Interface
Parameters:
- DATA_WIDTH, 8, chip data width (4 for 3601)
- ADDRESS_WIDTH, 9, chip address width (8 for 3601)
- SETTLE_CYCLES, 4, clk cycles between address/operation drive and data sample; legal range 1..255
- OP_IDLE, 4'b0000, operation code driven when not reading
- OP_READ, 4'b1100, operation code driven during a read (same for both chips)

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  sole clock, rising edge
- reset_n  input  1  synchronous reset, active-HIGH despite the suffix; sampled on rising clk
- start  input  1  level; in IDLE with mode_manual=0, begins a full sweep from address 0
- mode_manual  input  1  1 = manual stepping, 0 = auto sweep; sampled only in IDLE
- increment_address  input  1  manual step +1; rising-edge detected internally
- decrement_address  input  1  manual step −1; rising-edge detected internally
- data_line_in  input  DATA_WIDTH  data bus from the chip
- operation  output  4  V1..V4 (bit0 = V1)
- address_line  output  ADDRESS_WIDTH  chip address bus
- out_data  output  DATA_WIDTH  sampled word
- out_address  output  ADDRESS_WIDTH  address of out_data
- out_valid  output  1  out_data/out_address valid
- out_ready  input  1  downstream accepts when out_valid && out_ready
- out_mismatch  output  1  double-read disagreement (see Configuration)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last word of an auto sweep is accepted

## Operation
- States: IDLE, SETTLE, SAMPLE, HOLD, NEXT.
- IDLE:
  - operation = OP_IDLE; address_line holds the current address.
  - Auto (mode_manual=0): start=1 loads addr=0 and goes to SETTLE.
  - Manual: a detected increment or decrement edge updates addr and goes to SETTLE.
  - Both edges detected in the same cycle: no change, stay in IDLE.
- Manual arithmetic is modulo 2^ADDRESS_WIDTH: max+1 → 0, 0−1 → max.
- SETTLE:
  - operation = OP_READ, address_line = addr.
  - Counter runs SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: register data_line_in into out_data and addr into out_address; go to HOLD.
- HOLD:
  - out_valid = 1; out_data and out_address stay stable until the handshake.
  - On out_valid && out_ready: auto mode goes to NEXT; manual mode goes to IDLE.
- NEXT (auto only):
  - If addr == 2^ADDRESS_WIDTH−1: pulse done and go to IDLE; addr wraps to 0 and operation returns to OP_IDLE.
  - Otherwise: addr+1, go to SETTLE.
- Step edges arriving while busy are discarded; they are not queued.
- start held high after done does not retrigger. A new sweep requires start to be low for at least one IDLE cycle.
- Reset values: operation=OP_IDLE, address_line=0, out_data=0, out_address=0, out_valid=0, out_mismatch=0, busy=0, done=0, state=IDLE, edge detectors cleared (an input already high at reset release is not treated as an edge).
- Reset mid-operation: the next cycle returns to the reset values. The pending word is dropped and no done pulse is produced.

## Timing
- Auto latency: start sampled high at edge N → busy and OP_READ from N+1 → out_valid at N+SETTLE_CYCLES+2.
- Manual latency: step edge registered at edge N → same N+SETTLE_CYCLES+2 to out_valid.
- Back-to-back words (out_ready tied high): one word every SETTLE_CYCLES+3 cycles.
- Full 3604 sweep with defaults: 512 words in 512×7 cycles; done is the cycle after the final handshake.
- out_valid never drops without a handshake or a reset.

## Configuration
- ROM_READER_DOUBLE_READ_EN.
- Defined:
  - After SAMPLE, a second SETTLE_CYCLES wait, then a second sample.
  - out_data is the first sample.
  - out_mismatch = (first ≠ second), valid with out_valid.
  - Word period grows by SETTLE_CYCLES+1.
- Undefined: single sample; out_mismatch tied 0.

## Test plan
- Reset, then auto sweep with ADDRESS_WIDTH=9, DATA_WIDTH=8, ROM model data=addr[7:0]^8'h5A, out_ready=1 → 512 words in order 0..511, out_data matches the model, one done pulse, operation back to 4'b0000.
- Manual mode at addr 0: one decrement pulse → out_address=511. Then one increment pulse → out_address=0. Then both pulses in the same cycle → no read, busy stays 0.
- Backpressure: out_ready low for 20 cycles on word 3 → out_valid, out_data and out_address held stable; address_line stays 3; word 4 is not started until acceptance.
- reset_n asserted during SETTLE of word 100 → next cycle all outputs are at reset values; no done pulse; a fresh start restarts from address 0.
- With ROM_READER_DOUBLE_READ_EN: model flips bit 0 on the second read of address 7 → out_mismatch=1 only for word 7; without the macro → out_mismatch always 0.
- DATA_WIDTH=4, ADDRESS_WIDTH=8, SETTLE_CYCLES=1 → 256 words, period 4 cycles, done after word 255.

Source files
------------

// File: rtl/rom_sweep_reader.sv
// rom_sweep_reader: V1-V4 bipolar PROM reader with auto sweep and manual stepping.
// Optional double read with mismatch flag: ROM_READER_DOUBLE_READ_EN.
module rom_sweep_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [3:0] OP_IDLE = 4'b0000,
  parameter logic [3:0] OP_READ = 4'b1100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic mode_manual,
  input  logic increment_address,
  input  logic decrement_address,
  input  logic [DATA_WIDTH-1:0] data_line_in,
  output logic [3:0] operation,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic out_valid,
  input  logic out_ready,
  output logic out_mismatch,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_HOLD,
    S_NEXT,
    S_SETTLE2,
    S_SAMPLE2
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t state, state_nx;
  logic [ADDRESS_WIDTH-1:0] addr, addr_nx;
  logic [7:0] cnt;
  logic inc_q, dec_q;
  logic inc_edge, dec_edge;
  logic armed, manual;

  assign inc_edge = increment_address & ~inc_q;
  assign dec_edge = decrement_address & ~dec_q;

  assign operation = (state == S_IDLE) ? OP_IDLE : OP_READ;
  assign address_line = addr;
  assign busy = (state != S_IDLE);
  assign out_valid = (state == S_HOLD);

  always_comb begin
    state_nx = state;
    addr_nx = addr;
    done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!mode_manual) begin
          if (start && armed) begin
            addr_nx = '0;
            state_nx = S_SETTLE;
          end
        end else if (inc_edge ^ dec_edge) begin
          addr_nx = inc_edge ? addr + ADDR_ONE : addr - ADDR_ONE;
          state_nx = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == CNT_LAST) state_nx = S_SAMPLE;
      end
      S_SAMPLE: begin
`ifdef ROM_READER_DOUBLE_READ_EN
        state_nx = S_SETTLE2;
`else
        state_nx = S_HOLD;
`endif
      end
      S_SETTLE2: begin
        if (cnt == CNT_LAST) state_nx = S_SAMPLE2;
      end
      S_SAMPLE2: state_nx = S_HOLD;
      S_HOLD: begin
        if (out_ready) state_nx = manual ? S_IDLE : S_NEXT;
      end
      S_NEXT: begin
        if (addr == ADDR_MAX) begin
          done = 1'b1;
          addr_nx = '0;
          state_nx = S_IDLE;
        end else begin
          addr_nx = addr + ADDR_ONE;
          state_nx = S_SETTLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Edge history tracks the inputs even in reset, so a level held
  // across reset release is not mistaken for a fresh step.
  always_ff @(posedge clk) begin
    inc_q <= increment_address;
    dec_q <= decrement_address;
    if (reset_n) begin
      state <= S_IDLE;
      addr <= '0;
      cnt <= '0;
      armed <= 1'b1;
      manual <= 1'b0;
      out_data <= '0;
      out_address <= '0;
    end else begin
      state <= state_nx;
      addr <= addr_nx;
      if (state_nx != state) cnt <= '0;
      else cnt <= cnt + 8'd1;
      if (state == S_IDLE) begin
        manual <= mode_manual;
        if (!start) armed <= 1'b1;
        else if (!mode_manual) armed <= 1'b0;
      end
      if (state == S_SAMPLE) begin
        out_data <= data_line_in;
        out_address <= addr;
      end
    end
  end

`ifdef ROM_READER_DOUBLE_READ_EN
  always_ff @(posedge clk) begin
    if (reset_n) out_mismatch <= 1'b0;
    else if (state == S_SAMPLE2) out_mismatch <= (data_line_in != out_data);
  end
`else
  assign out_mismatch = 1'b0;
`endif

endmodule
